grf_scoreboard: RTL

GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

---
 rtl/grf_scoreboard.sv | 93 +++++++++
 1 files changed

// File: rtl/grf_scoreboard.sv
// GRF write scoreboard: tracks pending register writes and their forwarding countdowns, raises decode stall.
// Optional stall statistics counter enabled by defining SCOREBOARD_STAT_EN.
module grf_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs,
  input  logic [4:0] dec_rt,
  input  logic       dec_rs_use,
  input  logic       dec_rt_use,
  input  logic       dec_wr,
  input  logic [4:0] dec_rd,
  input  logic [1:0] dec_tnew,
  input  logic       wb_en,
  input  logic [4:0] wb_a3,
  input  logic       flush,
  output logic       stall,
  output logic       rs_pend,
  output logic       rt_pend,
  output logic [5:0] outstanding
`ifdef SCOREBOARD_STAT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 2;

  logic [NREG-1:0]  pend;
  logic [CNT_W-1:0] cnt [NREG];

  logic rs_blk, rt_blk, issue, wb_clr, inc, dec;

  // Source hazard detection; a same-cycle write-back bypasses the pending entry.
  always_comb begin
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    rs_blk  = 1'b0;
    rt_blk  = 1'b0;
    rs_pend = (dec_rs != 5'd0) && pend[dec_rs] && !(wb_en && (wb_a3 == dec_rs));
    rt_pend = (dec_rt != 5'd0) && pend[dec_rt] && !(wb_en && (wb_a3 == dec_rt));
    rs_blk  = dec_rs_use && rs_pend && (cnt[dec_rs] != 2'd0);
    rt_blk  = dec_rt_use && rt_pend && (cnt[dec_rt] != 2'd0);
    stall   = dec_valid && (rs_blk || rt_blk);
  end

  // Issue/retire qualification and occupancy deltas.
  always_comb begin
    issue  = 1'b0;
    wb_clr = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;
    issue  = dec_valid && !stall && dec_wr && (dec_rd != 5'd0);
    wb_clr = wb_en && (wb_a3 != 5'd0);
    inc    = issue && !pend[dec_rd];
    dec    = wb_clr && pend[wb_a3] && !(issue && (dec_rd == wb_a3));
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pend        <= '0;
      outstanding <= 6'd0;
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (issue && (dec_rd == 5'(i))) begin
          pend[i] <= 1'b1;
          cnt[i]  <= dec_tnew;
        end else if (wb_clr && (wb_a3 == 5'(i))) begin
          pend[i] <= 1'b0;
          cnt[i]  <= '0;
        end else if (cnt[i] != 2'd0) begin
          cnt[i]  <= cnt[i] - 2'd1;
        end
      end
      case ({inc, dec})
        2'b10:   outstanding <= outstanding + 6'd1;
        2'b01:   outstanding <= outstanding - 6'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef SCOREBOARD_STAT_EN
  // Counts stalled cycles; survives flush, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)      stall_cycles <= 32'd0;
    else if (stall) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
